// File: rtl/msg_pkg.sv
// msg_pkg: shared message types for the extractor and its output buffer.
// Holds byte/message sizing and the packed message bundle.
package msg_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int MSG_BYTES  = 32;
  localparam int MSG_DW     = MSG_BYTES * BYTE_WIDTH;

  typedef struct packed {
    logic [MSG_DW-1:0]    data;
    logic [MSG_BYTES-1:0] bytemask;
  } msg_t;

endpackage

// File: rtl/msg_popcount.sv
// msg_popcount: combinational count of set bits in a vector.
// Used to turn a stored bytemask into a byte length.
module msg_popcount #(
  parameter int W  = 32,
  parameter int LW = $clog2(W) + 1
) (
  input  logic [W-1:0]  vec,
  output logic [LW-1:0] count
);

  // Sum every bit of the vector.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++)
      count = count + LW'(vec[i]);
  end

endmodule

// File: rtl/msg_out_fifo.sv
// msg_out_fifo: message queue behind the extractor; drops when full.
// Define MSG_OUT_FIFO_DROP_CNT_EN to add the saturating drop_cnt port.
module msg_out_fifo
  import msg_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 8,
  parameter int LEN_WIDTH  = $clog2(MASK_WIDTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [MASK_WIDTH-1:0]     in_bytemask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [MASK_WIDTH-1:0]     out_bytemask,
  output logic [LEN_WIDTH-1:0]      out_len,
  output logic [$clog2(DEPTH):0]    level,
  input  logic                      ovf_clr,
  output logic                      overflow
`ifdef MSG_OUT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  if (DATA_WIDTH != MSG_DW) begin : g_bad_width
    $error("DATA_WIDTH must match msg_t");
  end

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  msg_t        mem [DEPTH];

  logic empty;
  logic full;
  logic push_req;
  logic pop;
  logic push;
  logic drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0])
              && (wr_ptr[PW] != rd_ptr[PW]);

  assign push_req = in_valid && (|in_bytemask);
  assign pop      = out_valid && out_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign out_valid    = !empty;
  assign level        = wr_ptr - rd_ptr;
  assign out_data     = mem[rd_ptr[PW-1:0]].data;
  assign out_bytemask = mem[rd_ptr[PW-1:0]].bytemask;

  msg_popcount #(
    .W  (MASK_WIDTH),
    .LW (LEN_WIDTH)
  ) u_len (
    .vec   (out_bytemask),
    .count (out_len)
  );

  // Advance pointers on accepted pushes and pops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write the accepted message into the tail slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[PW-1:0]].data     <= in_data;
      mem[wr_ptr[PW-1:0]].bytemask <= in_bytemask;
    end
  end

  // Sticky drop flag; a new drop beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef MSG_OUT_FIFO_DROP_CNT_EN
  // Saturating drop counter; clear with a drop leaves one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt <= '0;
    else if (ovf_clr)
      drop_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_msg_out_fifo.sv
// tb_msg_out_fifo: scoreboard bench for msg_out_fifo.
// Define MSG_OUT_FIFO_DROP_CNT_EN to also check drop_cnt.
module tb_msg_out_fifo;
  import msg_pkg::*;

  localparam int DW = 256;
  localparam int MW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [MW-1:0] in_bytemask;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [MW-1:0] out_bytemask;
  logic [5:0]    out_len;
  logic [3:0]    level;
  logic          ovf_clr;
  logic          overflow;
`ifdef MSG_OUT_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  msg_out_fifo dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_bytemask  (in_bytemask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_bytemask (out_bytemask),
    .out_len      (out_len),
    .level        (level),
    .ovf_clr      (ovf_clr),
    .overflow     (overflow)
`ifdef MSG_OUT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  msg_t sb [$];
  logic ovf_m;
  int   cnt_m;

  task automatic check(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic post_checks();
    check("valid", out_valid, sb.size() != 0);
    check("level", level, sb.size());
    check("ovf", overflow, ovf_m);
`ifdef MSG_OUT_FIFO_DROP_CNT_EN
    check("dcnt", drop_cnt, cnt_m);
`endif
  endtask

  // one clock: predict, compare pops, step edge, check state
  task automatic tick();
    bit pop_m, req_m, drop_m;
    msg_t m;
    pop_m  = (sb.size() != 0) && out_ready;
    req_m  = in_valid && (in_bytemask != '0);
    drop_m = req_m && (sb.size() == D) && !pop_m;
    if (pop_m) begin
      m = sb.pop_front();
      check("data", out_data, m.data);
      check("mask", out_bytemask, m.bytemask);
      check("len", out_len, $countones(m.bytemask));
    end
    if (req_m && !drop_m) begin
      m.data     = in_data;
      m.bytemask = in_bytemask;
      sb.push_back(m);
    end
    if (drop_m)       ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
    if (ovf_clr)
      cnt_m = drop_m ? 1 : 0;
    else if (drop_m && cnt_m != 65535)
      cnt_m++;
    @(posedge clk);
    @(negedge clk);
    post_checks();
  endtask

  task automatic push(
    input logic [DW-1:0] d,
    input logic [MW-1:0] k
  );
    in_valid    = 1'b1;
    in_data     = d;
    in_bytemask = k;
    tick();
    in_valid    = 1'b0;
  endtask

  function automatic logic [DW-1:0] mk(input int id);
    logic [DW-1:0] v;
    v = {8{32'(id) ^ 32'hA5A5_0000}};
    return v;
  endfunction

  logic [MW-1:0] masks [9];

  initial begin
    masks = '{32'h1, 32'h0000_0F0F, 32'hFFFF_FFFF,
              32'h8000_0001, 32'hFF, 32'h5555_5555,
              32'hF000_0000, 32'h0001_0000, 32'h3C};
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_bytemask = '0;
    out_ready   = 1'b0;
    ovf_clr     = 1'b0;
    ovf_m       = 1'b0;
    cnt_m       = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    post_checks();
    reset_n = 1'b1;
    tick();

    // single push, seen one cycle later, then popped
    out_ready = 1'b1;
    push(256'h01_0203_0405, 32'h1F);
    check("len5", out_len, 6'd5);
    tick();
    check("empty", level, 4'd0);

    // fill to full, then drop a ninth
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(mk(i), masks[i-1]);
    check("full", level, 4'd8);
    check("noovf", overflow, 1'b0);
    push(mk(99), 32'h7);
    check("ovf1", overflow, 1'b1);
    check("head1", out_data, mk(1));

    // clear coinciding with a drop keeps the flag
    ovf_clr = 1'b1;
    push(mk(98), 32'h3);
    ovf_clr = 1'b0;
    check("ovfkeep", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovfclr", overflow, 1'b0);

    // empty mask is ignored even when full
    push(mk(97), 32'h0);
    check("m0lvl", level, 4'd8);
    check("m0ovf", overflow, 1'b0);

    // push and pop at full on the same edge
    out_ready = 1'b1;
    push(mk(9), masks[8]);
    check("fullpp", level, 4'd8);
    check("head2", out_data, mk(2));
    repeat (8) tick();
    check("drained", level, 4'd0);

    // random traffic with concurrent push/pop
    for (int i = 0; i < 40; i++) begin
      out_ready   = 1'($urandom_range(0, 1));
      in_valid    = 1'($urandom_range(0, 1));
      in_data     = {8{$urandom}};
      in_bytemask = $urandom;
      if ($urandom_range(0, 7) == 0) in_bytemask = '0;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    // async reset mid-drain at level 5
    out_ready = 1'b0;
    for (int i = 20; i < 27; i++) push(mk(i), 32'hF);
    out_ready = 1'b1;
    repeat (2) tick();
    check("lvl5", level, 4'd5);
    #2 reset_n = 1'b0;
    #1;
    check("rstv", out_valid, 1'b0);
    check("rstl", level, 4'd0);
    sb.delete();
    ovf_m = 1'b0;
    cnt_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b0;
    push(mk(50), 32'hFFFF);
    check("postrst", out_valid, 1'b1);
    check("postlen", out_len, 6'd16);
    out_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_out_fifo.md
# msg_out_fifo

Message output buffer sitting directly downstream of the message extractor. It captures each extracted message: a 256-bit data word plus a 32-bit bytemask, delivered as a single-cycle `in_valid` pulse with no backpressure. It queues the messages in a small FIFO and presents them to the consumer over a valid/ready handshake with a computed byte length. Because the extractor cannot stall, overflow is handled by dropping the message and flagging it.

## Interface
- `DATA_WIDTH`, 256, message data width in bits; multiple of 8.
- `MASK_WIDTH`, `DATA_WIDTH/8`, bytemask width; one bit per byte.
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `LEN_WIDTH`, `$clog2(MASK_WIDTH)+1`, width of `out_len`.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  one message is presented this cycle.
- `in_data`  in  `DATA_WIDTH`  message bytes; byte i is `in_data[8i+:8]`.
- `in_bytemask`  in  `MASK_WIDTH`  bit i=1 means byte i is valid.
- `out_valid`  out  1  head entry is available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  `DATA_WIDTH`  head entry data.
- `out_bytemask`  out  `MASK_WIDTH`  head entry mask.
- `out_len`  out  `LEN_WIDTH`  popcount of `out_bytemask`.
- `level`  out  `$clog2(DEPTH)+1`  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: a message was dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow` (and the drop counter).
- `drop_cnt`  out  16  dropped-message count. Present only with `MSG_OUT_FIFO_DROP_CNT_EN`.

## Operation
- Storage is a circular buffer.
  - `wr_ptr` and `rd_ptr` are each `$clog2(DEPTH)+1` bits; the extra MSB disambiguates full from empty.
  - Empty: `wr_ptr==rd_ptr`.
  - Full: low bits equal and MSBs differ.
- Push:
  - A push occurs when `in_valid` is high and `in_bytemask!=0`.
  - A message with `in_bytemask==0` is silently discarded. It is neither stored nor counted as a drop.
- Pop: occurs when `out_valid && out_ready`.
- Push while full:
  - The push is accepted if a pop happens on the same edge. Occupancy stays at DEPTH.
  - Otherwise the message is dropped and `overflow` is set on that edge.
  - Stored entries are never overwritten.
- Simultaneous push and pop when not full: both occur and `level` is unchanged.
- `level` tracks the push/pop difference: +1, −1, or 0.
- Masks are stored verbatim. Non-contiguous masks are legal; `out_len` counts the set bits (e.g. mask `32'h0000_0F0F` gives len 8).
- `out_len` is combinational from the stored head mask. The full mask (`32'hFFFF_FFFF`) gives 32, so `out_len` needs `LEN_WIDTH` = 6 bits.
- `ovf_clr` in the same cycle as a new drop: the set wins, so `overflow` stays 1.

## Timing
- All outputs reset to zero while `reset_n` is low: `out_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0.
  - `out_data`, `out_bytemask`, `out_len` read the (reset) storage and are don't-care while `out_valid`=0.
  - The pointers reset to 0.
- Push-to-output latency is 1 cycle. A push at edge N gives `out_valid`=1 after edge N.
  - There is no combinational bypass from `in_*` to `out_*`.
- Valid/ready rules:
  - `out_valid` and the head fields stay stable until the pop edge.
  - `out_valid` never depends combinationally on `out_ready`.
- Back-to-back pops at full rate are supported: one entry per cycle.
- Reset mid-operation discards all contents immediately (asynchronous). The first push after deassertion behaves as if the FIFO were empty.

## Configuration
- `MSG_OUT_FIFO_DROP_CNT_EN` defined:
  - The `drop_cnt` port and a 16-bit counter are compiled in.
  - The counter increments by 1 on each dropped push and saturates at `16'hFFFF`.
  - `ovf_clr` zeroes it. If a drop happens in the same cycle as `ovf_clr`, the result is 1.
- Not defined: the port and counter are absent; only the sticky `overflow` flag reports drops.

## Structure
- Shared package `msg_pkg`:
  - `BYTE_WIDTH`=8 and `MSG_BYTES`=32.
  - Packed struct `msg_t {data, bytemask}`, also reused by the extractor's output.
- Sub-module `msg_popcount`: parameterised combinational popcount over `MASK_WIDTH` bits, producing `out_len`.
- Storage is an inferred register array of `msg_t`.

## Test plan
- Reset, then a single push of data=`256'h…0102030405` with mask `32'h1F` and `out_ready`=1: `out_valid` rises 1 cycle later with `out_len`=5, and the FIFO is empty after the pop.
- 8 pushes with `out_ready`=0 → `level`=8 and `overflow`=0. A 9th push → dropped, `overflow`=1, `drop_cnt`=1, `level`=8, and the head is still message 1.
- Full FIFO, push plus pop on the same edge → accepted, `level` stays 8, and the drain order is messages 2..9.
- A push with mask=0 → `level` unchanged, no overflow, `drop_cnt` unchanged.
- `ovf_clr` on the same cycle as a drop → `overflow`=1 and `drop_cnt`=1.
- Async reset asserted mid-drain with `level`=5 → `out_valid`=0 and `level`=0 immediately. A subsequent push appears 1 cycle later.
